parking_gate_controller: RTL and testbench
==========================================

Name: parking_gate_controller

Overview:
- Sequences the entry barrier and the exit barrier of the parking lot into the single-cycle event strobes consumed by parking_logic (car_entered/is_uni_car_entered, car_exited/is_uni_car_exited).
- Arbitrates the entry and exit gates so at most one event strobe is issued per cycle.
- Gates each entry on parking_logic's vacancy flags, and counts denied entries.

Parameters:
- OPEN_CYCLES, 4: cycles a barrier stays open after a grant; legal range is 2 or more.
- DENY_CNT_W, 8: width of the saturating deny counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ent_req  in  1  car waiting at the entry barrier (level).
- ent_is_uni  in  1  entry car is a university car; valid while ent_req is high.
- ext_req  in  1  car waiting at the exit barrier (level).
- ext_is_uni  in  1  exit car is a university car; valid while ext_req is high.
- uni_is_vacated_space  in  1  vacancy flag from parking_logic, university pool.
- is_vacated_space  in  1  vacancy flag from parking_logic, general pool.
- car_entered  out  1  one-cycle entry event to parking_logic.
- is_uni_car_entered  out  1  class of the entry event; valid with car_entered.
- car_exited  out  1  one-cycle exit event to parking_logic.
- is_uni_car_exited  out  1  class of the exit event; valid with car_exited.
- ent_ack  out  1  one-cycle pulse: entry accepted.
- ent_deny  out  1  one-cycle pulse: entry refused, lot full for that class.
- ext_ack  out  1  one-cycle pulse: exit accepted.
- ent_gate_open  out  1  entry barrier raised.
- ext_gate_open  out  1  exit barrier raised.
- deny_count  out  DENY_CNT_W  saturating count of denied entries.

Behaviour:
- Reset (reset=0, asynchronous): both gate FSMs go to IDLE, deny_count=0, and all outputs are 0.
  - Asserting reset mid-OPEN drops the gate_open outputs immediately.
  - No strobe is ever emitted for an interrupted grant.
- Each gate runs its own FSM with states IDLE, GRANT, OPEN and WAIT_DROP (WAIT_DROP is entry gate only). All outputs are registered.
- IDLE: the gate is eligible when its req=1.
- Arbitration when both gates are eligible in the same cycle:
  - The exit gate wins, because an exit frees space.
  - The entry gate stays in IDLE and is re-evaluated the next cycle.
  - car_entered and car_exited are never high in the same cycle.
- Exit decision in cycle N (eligible and winning):
  - Cycle N+1: car_exited=1, is_uni_car_exited=ext_is_uni as sampled in N, ext_ack=1.
  - ext_gate_open is high for cycles N+1 through N+OPEN_CYCLES.
  - The gate returns to IDLE at N+OPEN_CYCLES+1.
  - Exits are never refused. Underflow protection belongs to parking_logic.
- Entry decision in cycle N (eligible and winning):
  - Vacancy flag used: uni_is_vacated_space when ent_is_uni=1, otherwise is_vacated_space, both sampled in cycle N.
  - Flag = 1: in N+1, car_entered=1, is_uni_car_entered=ent_is_uni, ent_ack=1. ent_gate_open is high for N+1 through N+OPEN_CYCLES, then the gate returns to IDLE. The OPEN_CYCLES≥2 floor guarantees parking_logic has updated its vacancy flags before the next entry decision.
  - Flag = 0: in N+1, ent_deny=1 and deny_count increments; it saturates at 2^DENY_CNT_W-1 and does not wrap. The FSM goes to WAIT_DROP and stays there until ent_req=0, then returns to IDLE. One deny is issued per request; a held ent_req never produces repeated denies.
- Request-holding rules:
  - A req held during GRANT or OPEN is ignored.
  - A req still high when the gate returns to IDLE is treated as a new car, so requesters must drop req on ack.
- Strobes and ack/deny pulses are exactly one cycle wide and are low in every other cycle.

Optional Feature:
- Macro: PARKING_NIGHT_LOCK_EN.
- Defined:
  - Adds input port hour (5 bits, 0-23), placed after is_vacated_space.
  - An entry decided with hour<7 or hour≥22 is denied exactly as for a full lot (ent_deny, deny_count, WAIT_DROP), regardless of the vacancy flags.
  - Exits are unaffected.
- Not defined: no hour port, no time-based lockout.

Test Plan:
- Uni entry with uni_is_vacated_space=1, ent_req held until ent_ack, OPEN_CYCLES=4 -> one cycle of car_entered=1 with is_uni_car_entered=1, ent_gate_open high exactly 4 cycles, gate back to IDLE on the 5th cycle after the grant.
- Non-uni entry with is_vacated_space=0, ent_req held 10 cycles -> exactly one ent_deny pulse, deny_count=1, no car_entered; after ent_req drops and rises again with is_vacated_space=1 -> granted.
- ent_req and ext_req both rise in cycle N, both vacancy flags 1 -> car_exited in N+1, car_entered in N+2, never both high together.
- 300 denied entries with DENY_CNT_W=8 -> deny_count reads 255 and holds.
- reset driven low 2 cycles into OPEN -> both gate_open outputs go to 0 immediately, deny_count=0, no strobes for 3 cycles after reset release with all requests low.
- PARKING_NIGHT_LOCK_EN defined: uni entry at hour=23 with uni_is_vacated_space=1 -> ent_deny; same request at hour=8 -> ent_ack and car_entered; exit at hour=23 -> ext_ack.

Source files
------------

// File: rtl/parking_gate_controller.sv
// rtl/parking_gate_controller.sv - entry/exit barrier sequencer with exit-priority arbitration and deny counting
// Optional night lockout of entries is built when PARKING_NIGHT_LOCK_EN is defined (adds the hour input).
module parking_gate_controller #(
   parameter int OPEN_CYCLES = 4,
   parameter int DENY_CNT_W  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ent_req,
   input  logic                  ent_is_uni,
   input  logic                  ext_req,
   input  logic                  ext_is_uni,
   input  logic                  uni_is_vacated_space,
   input  logic                  is_vacated_space,
`ifdef PARKING_NIGHT_LOCK_EN
   input  logic [4:0]            hour,
`endif
   output logic                  car_entered,
   output logic                  is_uni_car_entered,
   output logic                  car_exited,
   output logic                  is_uni_car_exited,
   output logic                  ent_ack,
   output logic                  ent_deny,
   output logic                  ext_ack,
   output logic                  ent_gate_open,
   output logic                  ext_gate_open,
   output logic [DENY_CNT_W-1:0] deny_count
);

   // The GRANT cycle is the first open cycle; the counter covers the remaining OPEN_CYCLES-1.
   localparam int               CNT_W     = (OPEN_CYCLES > 2) ? $clog2(OPEN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] OPEN_LOAD = CNT_W'(OPEN_CYCLES - 2);

   typedef enum logic [1:0] {ENT_IDLE, ENT_GRANT, ENT_OPEN, ENT_WAIT_DROP} ent_state_t;
   typedef enum logic [1:0] {EXT_IDLE, EXT_GRANT, EXT_OPEN} ext_state_t;

   ent_state_t            ent_state_q, ent_state_d;
   ext_state_t            ext_state_q, ext_state_d;
   logic [CNT_W-1:0]      ent_cnt_q, ent_cnt_d;
   logic [CNT_W-1:0]      ext_cnt_q, ext_cnt_d;
   logic [DENY_CNT_W-1:0] deny_count_q, deny_count_d;
   logic car_entered_q, car_entered_d;
   logic is_uni_car_entered_q, is_uni_car_entered_d;
   logic car_exited_q, car_exited_d;
   logic is_uni_car_exited_q, is_uni_car_exited_d;
   logic ent_ack_q, ent_ack_d;
   logic ent_deny_q, ent_deny_d;
   logic ext_ack_q, ext_ack_d;
   logic ent_gate_open_q, ent_gate_open_d;
   logic ext_gate_open_q, ext_gate_open_d;

   logic ext_elig;
   logic ent_elig;
   logic ent_space;
   logic ent_locked;

   // Exit wins a simultaneous request because it frees space; entry retries next cycle.
   assign ext_elig  = (ext_state_q == EXT_IDLE) && ext_req;
   assign ent_elig  = (ent_state_q == ENT_IDLE) && ent_req && !ext_elig;
   assign ent_space = ent_is_uni ? uni_is_vacated_space : is_vacated_space;
`ifdef PARKING_NIGHT_LOCK_EN
   assign ent_locked = (hour < 5'd7) || (hour >= 5'd22);
`else
   assign ent_locked = 1'b0;
`endif

   // Exit gate: strobe on the grant, hold the barrier open, never refuse.
   always_comb begin
      ext_state_d         = ext_state_q;
      ext_cnt_d           = ext_cnt_q;
      car_exited_d        = 1'b0;
      is_uni_car_exited_d = 1'b0;
      ext_ack_d           = 1'b0;
      case (ext_state_q)
         EXT_IDLE: begin
            if (ext_elig) begin
               ext_state_d         = EXT_GRANT;
               car_exited_d        = 1'b1;
               is_uni_car_exited_d = ext_is_uni;
               ext_ack_d           = 1'b1;
            end
         end
         EXT_GRANT: begin
            ext_state_d = EXT_OPEN;
            ext_cnt_d   = OPEN_LOAD;
         end
         EXT_OPEN: begin
            if (ext_cnt_q == '0) ext_state_d = EXT_IDLE;
            else                 ext_cnt_d   = ext_cnt_q - CNT_W'(1);
         end
         default: ext_state_d = EXT_IDLE;
      endcase
      ext_gate_open_d = (ext_state_d == EXT_GRANT) || (ext_state_d == EXT_OPEN);
   end

   // Entry gate: grant on vacancy, otherwise deny once and wait for the request to drop.
   always_comb begin
      ent_state_d          = ent_state_q;
      ent_cnt_d            = ent_cnt_q;
      deny_count_d         = deny_count_q;
      car_entered_d        = 1'b0;
      is_uni_car_entered_d = 1'b0;
      ent_ack_d            = 1'b0;
      ent_deny_d           = 1'b0;
      case (ent_state_q)
         ENT_IDLE: begin
            if (ent_elig) begin
               if (ent_space && !ent_locked) begin
                  ent_state_d          = ENT_GRANT;
                  car_entered_d        = 1'b1;
                  is_uni_car_entered_d = ent_is_uni;
                  ent_ack_d            = 1'b1;
               end else begin
                  ent_state_d = ENT_WAIT_DROP;
                  ent_deny_d  = 1'b1;
                  if (deny_count_q != '1) deny_count_d = deny_count_q + DENY_CNT_W'(1);
               end
            end
         end
         ENT_GRANT: begin
            ent_state_d = ENT_OPEN;
            ent_cnt_d   = OPEN_LOAD;
         end
         ENT_OPEN: begin
            if (ent_cnt_q == '0) ent_state_d = ENT_IDLE;
            else                 ent_cnt_d   = ent_cnt_q - CNT_W'(1);
         end
         ENT_WAIT_DROP: begin
            if (!ent_req) ent_state_d = ENT_IDLE;
         end
         default: ent_state_d = ENT_IDLE;
      endcase
      ent_gate_open_d = (ent_state_d == ENT_GRANT) || (ent_state_d == ENT_OPEN);
   end

   // State and registered outputs; reset clears everything at once, so an interrupted grant emits nothing.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ent_state_q          <= ENT_IDLE;
         ext_state_q          <= EXT_IDLE;
         ent_cnt_q            <= '0;
         ext_cnt_q            <= '0;
         deny_count_q         <= '0;
         car_entered_q        <= 1'b0;
         is_uni_car_entered_q <= 1'b0;
         car_exited_q         <= 1'b0;
         is_uni_car_exited_q  <= 1'b0;
         ent_ack_q            <= 1'b0;
         ent_deny_q           <= 1'b0;
         ext_ack_q            <= 1'b0;
         ent_gate_open_q      <= 1'b0;
         ext_gate_open_q      <= 1'b0;
      end else begin
         ent_state_q          <= ent_state_d;
         ext_state_q          <= ext_state_d;
         ent_cnt_q            <= ent_cnt_d;
         ext_cnt_q            <= ext_cnt_d;
         deny_count_q         <= deny_count_d;
         car_entered_q        <= car_entered_d;
         is_uni_car_entered_q <= is_uni_car_entered_d;
         car_exited_q         <= car_exited_d;
         is_uni_car_exited_q  <= is_uni_car_exited_d;
         ent_ack_q            <= ent_ack_d;
         ent_deny_q           <= ent_deny_d;
         ext_ack_q            <= ext_ack_d;
         ent_gate_open_q      <= ent_gate_open_d;
         ext_gate_open_q      <= ext_gate_open_d;
      end
   end

   assign car_entered        = car_entered_q;
   assign is_uni_car_entered = is_uni_car_entered_q;
   assign car_exited         = car_exited_q;
   assign is_uni_car_exited  = is_uni_car_exited_q;
   assign ent_ack            = ent_ack_q;
   assign ent_deny           = ent_deny_q;
   assign ext_ack            = ext_ack_q;
   assign ent_gate_open      = ent_gate_open_q;
   assign ext_gate_open      = ext_gate_open_q;
   assign deny_count         = deny_count_q;

endmodule

// File: tb/tb_parking_gate_controller.sv
// tb/tb_parking_gate_controller.sv - self-checking bench for parking_gate_controller
module tb_parking_gate_controller;
   localparam int OPEN = 4;
   localparam int DW   = 8;
   localparam int DMAX = (1 << DW) - 1;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic ent_req = 1'b0, ent_is_uni = 1'b0, ext_req = 1'b0, ext_is_uni = 1'b0;
   logic uni_vac = 1'b0, vac = 1'b0;
`ifdef PARKING_NIGHT_LOCK_EN
   logic [4:0] hour = 5'd12;
`endif
   logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
   logic ent_ack, ent_deny, ext_ack, ent_gate_open, ext_gate_open;
   logic [DW-1:0] deny_count;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   parking_gate_controller #(.OPEN_CYCLES(OPEN), .DENY_CNT_W(DW)) dut (
      .clk(clk), .reset(reset),
      .ent_req(ent_req), .ent_is_uni(ent_is_uni),
      .ext_req(ext_req), .ext_is_uni(ext_is_uni),
      .uni_is_vacated_space(uni_vac), .is_vacated_space(vac),
`ifdef PARKING_NIGHT_LOCK_EN
      .hour(hour),
`endif
      .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
      .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
      .ent_ack(ent_ack), .ent_deny(ent_deny), .ext_ack(ext_ack),
      .ent_gate_open(ent_gate_open), .ext_gate_open(ext_gate_open),
      .deny_count(deny_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ent_req = 0; ext_req = 0; ent_is_uni = 0; ext_is_uni = 0; uni_vac = 0; vac = 0;
`ifdef PARKING_NIGHT_LOCK_EN
      hour = 5'd12;
`endif
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 0;
      tick(); tick();
      reset = 1;
      tick();
   endtask

   task automatic test_reset();
      reset = 0;
      ent_req = 1; ext_req = 1; uni_vac = 1; vac = 1; ent_is_uni = 1; ext_is_uni = 1;
      #2;
      checks++;
      if ({car_entered, is_uni_car_entered, car_exited, is_uni_car_exited, ent_ack, ent_deny,
           ext_ack, ent_gate_open, ext_gate_open} !== 9'b0) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=0", {car_entered, is_uni_car_entered, car_exited,
                  is_uni_car_exited, ent_ack, ent_deny, ext_ack, ent_gate_open, ext_gate_open});
      end
      tick(); tick();
      checks++;
      if (deny_count !== '0 || car_entered !== 1'b0 || car_exited !== 1'b0) begin
         failures++;
         $display("FAIL reset_held got deny=%0d ce=%b cx=%b exp 0", deny_count, car_entered, car_exited);
      end
      idle_inputs();
      reset = 1;
      tick();
   endtask

   task automatic test_uni_entry();
      int opens = 0;
      int strobes = 0;
      do_reset();
      ent_req = 1; ent_is_uni = 1; uni_vac = 1; vac = 0;
      tick();
      checks++;
      if ({car_entered, is_uni_car_entered, ent_ack, ent_gate_open, ent_deny} !== 5'b11110) begin
         failures++;
         $display("FAIL uni_entry_grant got=%b exp=11110",
                  {car_entered, is_uni_car_entered, ent_ack, ent_gate_open, ent_deny});
      end
      ent_req = 0;
      for (int i = 2; i <= OPEN; i++) begin
         tick();
         opens += int'(ent_gate_open);
         strobes += int'(car_entered) + int'(ent_ack);
         if (i == OPEN) ent_req = 1;
      end
      checks++;
      if (opens != OPEN - 1 || strobes != 0) begin
         failures++;
         $display("FAIL uni_entry_open got opens=%0d strobes=%0d exp %0d 0", opens, strobes, OPEN - 1);
      end
      tick();
      checks++;
      if (ent_gate_open !== 1'b0 || ent_ack !== 1'b0) begin
         failures++;
         $display("FAIL uni_entry_close got open=%b ack=%b exp 0 0", ent_gate_open, ent_ack);
      end
      tick();
      checks++;
      if (ent_ack !== 1'b1 || car_entered !== 1'b1) begin
         failures++;
         $display("FAIL uni_entry_regrant got ack=%b ce=%b exp 1 1", ent_ack, car_entered);
      end
      ent_req = 0;
      repeat (OPEN + 2) tick();
   endtask

   task automatic test_deny_hold();
      int denies = 0;
      int ents = 0;
      do_reset();
      ent_is_uni = 0; vac = 0; uni_vac = 1; ent_req = 1;
      for (int i = 0; i < 10; i++) begin
         tick();
         denies += int'(ent_deny);
         ents += int'(car_entered);
      end
      ent_req = 0;
      checks++;
      if (denies != 1 || ents != 0 || deny_count !== DW'(1)) begin
         failures++;
         $display("FAIL deny_hold got denies=%0d ents=%0d cnt=%0d exp 1 0 1", denies, ents, deny_count);
      end
      vac = 1;
      tick();
      ent_req = 1;
      tick();
      checks++;
      if (ent_ack !== 1'b1 || car_entered !== 1'b1 || is_uni_car_entered !== 1'b0 || deny_count !== DW'(1)) begin
         failures++;
         $display("FAIL deny_then_grant got ack=%b ce=%b uni=%b cnt=%0d exp 1 1 0 1",
                  ent_ack, car_entered, is_uni_car_entered, deny_count);
      end
      ent_req = 0;
      repeat (OPEN + 2) tick();
   endtask

   task automatic test_simultaneous();
      logic eu, xu;
      do_reset();
      eu = 1'($urandom_range(0, 1));
      xu = 1'($urandom_range(0, 1));
      ent_req = 1; ext_req = 1; uni_vac = 1; vac = 1; ent_is_uni = eu; ext_is_uni = xu;
      tick();
      checks++;
      if ({car_exited, is_uni_car_exited, ext_ack, ext_gate_open, car_entered} !== {1'b1, xu, 1'b1, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL simul_exit_first got=%b exp=%b",
                  {car_exited, is_uni_car_exited, ext_ack, ext_gate_open, car_entered}, {1'b1, xu, 1'b1, 1'b1, 1'b0});
      end
      ext_req = 0;
      tick();
      checks++;
      if ({car_entered, is_uni_car_entered, ent_ack, car_exited} !== {1'b1, eu, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL simul_entry_second got=%b exp=%b",
                  {car_entered, is_uni_car_entered, ent_ack, car_exited}, {1'b1, eu, 1'b1, 1'b0});
      end
      ent_req = 0;
      repeat (OPEN + 2) tick();
   endtask

   task automatic test_saturation();
      int pulses = 0;
      do_reset();
      vac = 0; ent_is_uni = 0;
      for (int i = 0; i < 300; i++) begin
         ent_req = 1;
         tick();
         pulses += int'(ent_deny);
         ent_req = 0;
         tick();
         if (i == 199) begin
            checks++;
            if (deny_count !== DW'(200)) begin
               failures++;
               $display("FAIL sat_mid got=%0d exp=200", deny_count);
            end
         end
      end
      checks++;
      if (deny_count !== DW'(DMAX) || pulses != 300) begin
         failures++;
         $display("FAIL sat_final got cnt=%0d pulses=%0d exp %0d 300", deny_count, pulses, DMAX);
      end
   endtask

   task automatic test_reset_mid_open();
      do_reset();
      vac = 0; ent_req = 1;
      tick();
      ent_req = 0;
      tick();
      vac = 1; uni_vac = 1; ent_req = 1; ext_req = 1;
      tick();
      ext_req = 0;
      tick();
      ent_req = 0;
      tick(); tick();
      checks++;
      if (ent_gate_open !== 1'b1 || ext_gate_open !== 1'b1 || deny_count !== DW'(1)) begin
         failures++;
         $display("FAIL pre_reset_open got eo=%b xo=%b cnt=%0d exp 1 1 1", ent_gate_open, ext_gate_open, deny_count);
      end
      reset = 0;
      #1;
      checks++;
      if (ent_gate_open !== 1'b0 || ext_gate_open !== 1'b0 || deny_count !== '0) begin
         failures++;
         $display("FAIL async_reset got eo=%b xo=%b cnt=%0d exp 0 0 0", ent_gate_open, ext_gate_open, deny_count);
      end
      tick();
      reset = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({car_entered, car_exited, ent_ack, ent_deny, ext_ack, ent_gate_open, ext_gate_open} !== 7'b0) begin
            failures++;
            $display("FAIL post_reset_quiet got=%b exp=0",
                     {car_entered, car_exited, ent_ack, ent_deny, ext_ack, ent_gate_open, ext_gate_open});
         end
      end
   endtask

`ifdef PARKING_NIGHT_LOCK_EN
   task automatic test_night_lock();
      do_reset();
      hour = 5'd23; ent_is_uni = 1; uni_vac = 1; vac = 1; ent_req = 1;
      tick();
      checks++;
      if (ent_deny !== 1'b1 || car_entered !== 1'b0 || deny_count !== DW'(1)) begin
         failures++;
         $display("FAIL night_deny got deny=%b ce=%b cnt=%0d exp 1 0 1", ent_deny, car_entered, deny_count);
      end
      ent_req = 0;
      tick();
      hour = 5'd8; ent_req = 1;
      tick();
      checks++;
      if (ent_ack !== 1'b1 || car_entered !== 1'b1) begin
         failures++;
         $display("FAIL day_grant got ack=%b ce=%b exp 1 1", ent_ack, car_entered);
      end
      ent_req = 0; hour = 5'd23; ext_req = 1;
      tick();
      checks++;
      if (ext_ack !== 1'b1 || car_exited !== 1'b1) begin
         failures++;
         $display("FAIL night_exit got ack=%b cx=%b exp 1 1", ext_ack, car_exited);
      end
      ext_req = 0;
      repeat (OPEN + 2) tick();
   endtask
`endif

   // Reference: each gate is busy until a timestamp after a grant; a deny blocks entry until req drops.
   task automatic test_random();
      int ent_free, ext_free, ent_gnt, ext_gnt, dcnt;
      bit ent_blk, ext_e, ent_e, ok, night;
      bit p_ent, p_ent_uni, p_ext, p_ext_uni, p_deny;
      bit exp_eo, exp_xo;
      do_reset();
      ent_free = 0; ext_free = 0; ent_gnt = -100; ext_gnt = -100; dcnt = 0; ent_blk = 0;
      p_ent = 0; p_ent_uni = 0; p_ext = 0; p_ext_uni = 0; p_deny = 0;
      for (int k = 0; k < 3000; k++) begin
         exp_eo = (k > ent_gnt) && (k <= ent_gnt + OPEN);
         exp_xo = (k > ext_gnt) && (k <= ext_gnt + OPEN);
         checks++;
         if ({car_entered, is_uni_car_entered, ent_ack, ent_deny} !== {p_ent, p_ent_uni, p_ent, p_deny}) begin
            failures++;
            $display("FAIL rand_entry k=%0d got=%b exp=%b", k,
                     {car_entered, is_uni_car_entered, ent_ack, ent_deny}, {p_ent, p_ent_uni, p_ent, p_deny});
         end
         checks++;
         if ({car_exited, is_uni_car_exited, ext_ack} !== {p_ext, p_ext_uni, p_ext}) begin
            failures++;
            $display("FAIL rand_exit k=%0d got=%b exp=%b", k,
                     {car_exited, is_uni_car_exited, ext_ack}, {p_ext, p_ext_uni, p_ext});
         end
         checks++;
         if ({ent_gate_open, ext_gate_open} !== {exp_eo, exp_xo}) begin
            failures++;
            $display("FAIL rand_gates k=%0d got=%b exp=%b", k, {ent_gate_open, ext_gate_open}, {exp_eo, exp_xo});
         end
         checks++;
         if (deny_count !== DW'(dcnt)) begin
            failures++;
            $display("FAIL rand_deny_count k=%0d got=%0d exp=%0d", k, deny_count, dcnt);
         end

         ent_req    = ($urandom % 3) != 0;
         ext_req    = ($urandom % 3) == 0;
         ent_is_uni = 1'($urandom % 2);
         ext_is_uni = 1'($urandom % 2);
         uni_vac    = 1'($urandom % 2);
         vac        = 1'($urandom % 2);
         night      = 0;
`ifdef PARKING_NIGHT_LOCK_EN
         hour  = 5'($urandom_range(0, 23));
         night = (hour < 7) || (hour >= 22);
`endif
         ext_e = ext_req && (k >= ext_free);
         ent_e = ent_req && !ent_blk && (k >= ent_free) && !ext_e;
         p_ent = 0; p_ent_uni = 0; p_ext = 0; p_ext_uni = 0; p_deny = 0;
         if (ext_e) begin
            p_ext = 1; p_ext_uni = ext_is_uni; ext_gnt = k; ext_free = k + OPEN + 1;
         end
         if (ent_blk && !ent_req) ent_blk = 0;
         if (ent_e) begin
            ok = (ent_is_uni ? uni_vac : vac) && !night;
            if (ok) begin
               p_ent = 1; p_ent_uni = ent_is_uni; ent_gnt = k; ent_free = k + OPEN + 1;
            end else begin
               p_deny = 1; ent_blk = 1;
               if (dcnt < DMAX) dcnt++;
            end
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_uni_entry();
      test_deny_hold();
      test_simultaneous();
      test_saturation();
      test_reset_mid_open();
`ifdef PARKING_NIGHT_LOCK_EN
      test_night_lock();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
